// File: rtl/serial_alu_ctrl_pkg.sv
// Shared constants for the bit-serial ALU: alu_ctrl codes, slice op field
// encodings and FSM state codes.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Start/done request bus between the decode stage and the serial ALU sequencer.
interface serial_alu_ctrl_if #(parameter int WIDTH = 32);

  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             zero;

  modport master (
    output start, alu_ctrl, src_a, src_b,
    input  busy, done, result, overflow, zero
  );

  modport slave (
    input  start, alu_ctrl, src_a, src_b,
    output busy, done, result, overflow, zero
  );

endinterface

// File: rtl/serial_alu_ctrl_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, full adder and
// 4:1 result mux; set is the raw sum, overflow compares carry in and out.
module serial_alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       c_in,
  input  logic [1:0] op,
  output logic       result,
  output logic       c_out,
  output logic       set,
  output logic       overflow
);

  logic a_eff;
  logic b_eff;
  logic sum;

  assign a_eff    = a ^ a_invert;
  assign b_eff    = b ^ b_invert;
  assign sum      = a_eff ^ b_eff ^ c_in;
  assign c_out    = (a_eff & b_eff) | (c_in & (a_eff ^ b_eff));
  assign set      = sum;
  assign overflow = c_in ^ c_out;

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_ADD:  result = sum;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives one ALU slice LSB-first for WIDTH cycles.
// Define SERIAL_ALU_ZERO_FLAG_EN to build the registered zero flag.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_alu_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic slice_res;
  logic slice_cout;
  logic slice_set;
  logic slice_ovf;

  serial_alu_slice u_slice (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .less     (1'b0),
    .a_invert (ctrl_q[3]),
    .b_invert (ctrl_q[2]),
    .c_in     (carry_q),
    .op       (ctrl_q[1:0]),
    .result   (slice_res),
    .c_out    (slice_cout),
    .set      (slice_set),
    .overflow (slice_ovf)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    result_d = result_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          ctrl_d  = bus.alu_ctrl;
          carry_d = bus.alu_ctrl[2];
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = {slice_res, result_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        idx_d    = idx_q + 1'b1;
        // Final result and flags are settled on entry to FIN so they are valid alongside done.
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          ovf_d   = slice_ovf;
          state_d = ST_FIN;
          if (ctrl_q[1:0] == OP_LESS) begin
            result_d = {{(WIDTH-1){1'b0}}, slice_set ^ slice_ovf};
          end
`ifdef SERIAL_ALU_ZERO_FLAG_EN
          zero_d = ~|result_d;
`endif
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  assign bus.zero     = zero_q;
`else
  assign bus.zero     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl at WIDTH=32 and the WIDTH=2 boundary.
module tb_serial_alu_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   acc;
  int   seen;
  logic exp_zero;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_alu_ctrl_if #(.WIDTH(32)) bus32 ();
  serial_alu_ctrl_if #(.WIDTH(2))  bus2 ();

  serial_alu_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  serial_alu_ctrl #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns cycles from the accept cycle to the done cycle, or -1 on timeout.
  task automatic wait_done32(input int acc_cyc, output int latency);
    latency = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus32.done === 1'b1) begin
        latency = cyc - acc_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                output int latency);
    int acc_cyc;
    @(negedge clk);
    bus32.alu_ctrl = ctrl;
    bus32.src_a    = a;
    bus32.src_b    = b;
    bus32.start    = 1'b1;
    acc_cyc        = cyc;
    @(negedge clk);
    bus32.start = 1'b0;
    wait_done32(acc_cyc, latency);
  endtask

  task automatic apply_stimulus2(input logic [3:0] ctrl, input logic [1:0] a, input logic [1:0] b,
                                 output int latency);
    int acc_cyc;
    @(negedge clk);
    bus2.alu_ctrl = ctrl;
    bus2.src_a    = a;
    bus2.src_b    = b;
    bus2.start    = 1'b1;
    acc_cyc       = cyc;
    @(negedge clk);
    bus2.start = 1'b0;
    latency = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus2.done === 1'b1) begin
        latency = cyc - acc_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus32.start    = 1'b0;
    bus32.alu_ctrl = 4'h0;
    bus32.src_a    = '0;
    bus32.src_b    = '0;
    bus2.start     = 1'b0;
    bus2.alu_ctrl  = 4'h0;
    bus2.src_a     = '0;
    bus2.src_b     = '0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 64'(bus32.busy), 64'd0);
    check_output("rst_done", 64'(bus32.done), 64'd0);
    check_output("rst_result", 64'(bus32.result), 64'd0);
    check_output("rst_ovf", 64'(bus32.overflow), 64'd0);
    check_output("rst_zero", 64'(bus32.zero), 64'd0);
    check_output("rst_result_w2", 64'(bus2.result), 64'd0);
    rst_n = 1'b1;

    // ADD with signed overflow, latency and post-done handshake
    apply_stimulus(CTRL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    check_output("add_lat", 64'(lat), 64'd33);
    check_output("add_result", 64'(bus32.result), 64'h8000_0000);
    check_output("add_ovf", 64'(bus32.overflow), 64'd1);
    check_output("add_zero", 64'(bus32.zero), 64'd0);
    check_output("add_busy_at_done", 64'(bus32.busy), 64'd1);
    @(negedge clk);
    check_output("add_done_pulse", 64'(bus32.done), 64'd0);
    check_output("add_busy_after", 64'(bus32.busy), 64'd0);
    check_output("add_result_held", 64'(bus32.result), 64'h8000_0000);

`ifdef SERIAL_ALU_ZERO_FLAG_EN
    exp_zero = 1'b1;
`else
    exp_zero = 1'b0;
`endif
    apply_stimulus(CTRL_SUB, 32'd5, 32'd5, lat);
    check_output("sub_lat", 64'(lat), 64'd33);
    check_output("sub_result", 64'(bus32.result), 64'd0);
    check_output("sub_zero", 64'(bus32.zero), 64'(exp_zero));
    check_output("sub_ovf", 64'(bus32.overflow), 64'd0);

    apply_stimulus(CTRL_SLT, 32'hFFFF_FFFD, 32'h0000_0002, lat);
    check_output("slt_neg_result", 64'(bus32.result), 64'd1);
    check_output("slt_neg_zero", 64'(bus32.zero), 64'd0);
    apply_stimulus(CTRL_SLT, 32'h8000_0000, 32'h0000_0001, lat);
    check_output("slt_ovf_result", 64'(bus32.result), 64'd1);
    check_output("slt_ovf_flag", 64'(bus32.overflow), 64'd1);
    apply_stimulus(CTRL_SLT, 32'h0000_0002, 32'hFFFF_FFFD, lat);
    check_output("slt_pos_result", 64'(bus32.result), 64'd0);

    apply_stimulus(CTRL_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF, lat);
    check_output("and_result", 64'(bus32.result), 64'h00F0_A5A5);
    apply_stimulus(CTRL_OR, 32'hF0F0_A5A5, 32'h0FF0_FFFF, lat);
    check_output("or_result", 64'(bus32.result), 64'hFFF0_FFFF);
    apply_stimulus(CTRL_NOR, 32'hF0F0_A5A5, 32'h0FF0_FFFF, lat);
    check_output("nor_result", 64'(bus32.result), 64'h000F_0000);

    // start held every cycle with operands changing under a running op
    @(negedge clk);
    bus32.alu_ctrl = CTRL_ADD;
    bus32.src_a    = 32'd3;
    bus32.src_b    = 32'd4;
    bus32.start    = 1'b1;
    acc            = cyc;
    lat            = -1;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (bus32.done === 1'b1) begin
        lat = cyc - acc;
        break;
      end
      bus32.src_a = 32'(i * 7);
      bus32.src_b = 32'(i + 1000);
    end
    check_output("stream_lat", 64'(lat), 64'd33);
    check_output("stream_result", 64'(bus32.result), 64'd7);
    bus32.src_a = 32'd10;
    bus32.src_b = 32'd20;
    @(negedge clk);
    check_output("stream_idle_gap", 64'(bus32.busy), 64'd0);
    acc = cyc;
    @(negedge clk);
    check_output("stream_reaccept", 64'(bus32.busy), 64'd1);
    bus32.start = 1'b0;
    wait_done32(acc, lat);
    check_output("stream2_lat", 64'(lat), 64'd33);
    check_output("stream2_result", 64'(bus32.result), 64'd30);

    // synchronous reset while the sequencer is on bit 10
    @(negedge clk);
    bus32.alu_ctrl = CTRL_ADD;
    bus32.src_a    = 32'h1234_5678;
    bus32.src_b    = 32'h0000_0001;
    bus32.start    = 1'b1;
    acc            = cyc;
    @(negedge clk);
    bus32.start = 1'b0;
    while (cyc < acc + 11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("abort_busy", 64'(bus32.busy), 64'd0);
    check_output("abort_result", 64'(bus32.result), 64'd0);
    check_output("abort_done", 64'(bus32.done), 64'd0);
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done === 1'b1) seen++;
    end
    check_output("abort_no_done", 64'(seen), 64'd0);
    apply_stimulus(CTRL_ADD, 32'd1, 32'd1, lat);
    check_output("post_abort_lat", 64'(lat), 64'd33);
    check_output("post_abort_result", 64'(bus32.result), 64'd2);

    // WIDTH=2 boundary: two RUN cycles
    apply_stimulus2(CTRL_ADD, 2'b01, 2'b01, lat);
    check_output("w2_add_lat", 64'(lat), 64'd3);
    check_output("w2_add_result", 64'(bus2.result), 64'h2);
    check_output("w2_add_ovf", 64'(bus2.overflow), 64'd1);
    apply_stimulus2(CTRL_SUB, 2'b01, 2'b10, lat);
    check_output("w2_sub_result", 64'(bus2.result), 64'h3);
    check_output("w2_sub_ovf", 64'(bus2.overflow), 64'd1);
    apply_stimulus2(CTRL_SLT, 2'b10, 2'b01, lat);
    check_output("w2_slt_result", 64'(bus2.result), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
